sensor_conditioner: RTL and testbench
=====================================

# sensor_conditioner

Input conditioning stage for the automatic door controller. Sits between the raw presence and obstacle sensor pins and the door state machine's `sense`/`obs` inputs. Synchronises both inputs to `clk`, debounces them, and stretches presence so short detection gaps do not start a close. Also flags an obstacle sensor that stays asserted too long.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive differing cycles needed to accept a new input level (10 ms at 50 MHz); must be ≥ 1.
- `HOLD_CYCLES`, 50000000: cycles that `sense` stays high after the debounced presence falls (1 s); 0 disables stretching.
- `FAULT_CYCLES`, 500000000: cycles of continuous debounced obstacle before `obs_fault` is raised (10 s); must be ≥ 1.
- `clk` in 1: system clock, 50 MHz. One clock only; all state is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `sense_raw` in 1: raw presence sensor, asynchronous to `clk`.
- `obs_raw` in 1: raw obstacle sensor, asynchronous to `clk`.
- `sense` out 1: conditioned, stretched presence to the door FSM.
- `obs` out 1: conditioned obstacle to the door FSM; never stretched.
- `sense_rise` out 1: one-cycle pulse on each 0→1 of `sense`.
- `obs_fault` out 1: obstacle stuck-high indication.

## Operation
- **Synchroniser:** each raw input passes through two flops, `s1` then `s2`; both reset to 0.
- **Debounce (per channel):**
  - Holds a `stable` register, reset 0, and a counter, reset 0.
  - If `s2 == stable`: counter clears to 0.
  - If they differ and counter < `DEBOUNCE_CYCLES-1`: counter increments.
  - If they differ and counter == `DEBOUNCE_CYCLES-1`: `stable` takes `s2` and counter clears.
  - Any single agreeing cycle restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach the outputs.
- **Presence stretch:**
  - `hold` counter, width `$clog2(HOLD_CYCLES+1)`, reset 0.
  - On the edge where `stable_sense` goes 1→0, `hold` loads `HOLD_CYCLES`.
  - While `stable_sense`=0 and `hold`≠0, `hold` decrements by 1 each cycle.
  - While `stable_sense`=1, `hold` is 0.
  - `sense = stable_sense | (hold != 0)`.
  - A re-detection during hold cancels the countdown; `sense` stays high with no dip.
- **Rise pulse:** registered copy `sense_d`, reset 0; `sense_rise = sense & ~sense_d`. A re-detection during hold produces no pulse.
- **Obstacle:** `obs = stable_obs`.
- **Obstacle fault:**
  - Fault counter increments, saturating at `FAULT_CYCLES`, while `stable_obs`=1; it clears to 0 when `stable_obs`=0.
  - `obs_fault = (counter == FAULT_CYCLES)`.
  - The fault is therefore sticky until the debounced obstacle drops.
- **Reset values:** all outputs are 0 during and after reset. Reset mid-debounce or mid-hold discards all progress; after release every channel restarts from 0.

## Timing
- **Assert latency:** a raw level change held steady is visible at the outputs `DEBOUNCE_CYCLES + 2` rising edges after the first edge that samples it. Of these, 2 are synchroniser cycles and `DEBOUNCE_CYCLES` are counter cycles.
- **Presence release:** debounced presence falls after the same latency; `sense` then stays high for exactly `HOLD_CYCLES` further cycles.
- **Rise pulse:** `sense_rise` is high in the first cycle `sense` is high, for exactly one cycle.
- **Fault:** `obs_fault` rises `FAULT_CYCLES` cycles after `obs` rises. It falls in the same cycle `obs` falls.
- **Independence:** both channels are independent; simultaneous changes on both inputs are each handled with identical latency.
- **Output decode:** outputs are combinational decodes of registers only; there is no raw-input-to-output combinational path.

## Structure
- Shared package/header `puerta_pkg`:
  - `CLK_HZ` = 50000000.
  - Default millisecond-to-cycle constants used for the three parameters.
  - No typedefs required.
- One sub-module, `debounce_channel`: synchroniser plus debounce, parameter `DEBOUNCE_CYCLES`, ports `clk`, `rst`, `din`, `dout`. Instantiated twice.
- Stretch, rise-pulse and fault logic live in the top module.

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=8, `FAULT_CYCLES`=16.
1. **Clean assert:** `sense_raw` 0→1 sampled at edge 0 → `sense` and `sense_rise` high after edge 5; `sense_rise` low after edge 6.
2. **Glitch rejection:** pulse `sense_raw` high for 3 cycles, and separately `obs_raw` high 3 cycles, low 1 cycle, high 3 cycles → `sense` and `obs` stay 0.
3. **Hold stretch:** `sense_raw` high 20 cycles then low → `sense` high until 8 cycles after debounced fall. Re-asserting `sense_raw` so debounced presence returns at hold count 3 → `sense` never drops and `sense_rise` does not pulse.
4. **Obstacle fault:** `obs_raw` high 30 cycles → `obs_fault` rises 16 cycles after `obs`. Dropping `obs_raw` → `obs_fault` and `obs` fall together, 6 edges later.
5. **Reset mid-operation:** assert `rst` mid-debounce (counter=2) and mid-hold (hold=5) → all outputs 0 immediately. After release with inputs held high, the full 6-edge latency applies again.
6. **Simultaneous inputs:** `sense_raw` and `obs_raw` rise on the same edge → `sense` and `obs` rise in the same cycle, 6 edges later.

Source files
------------

// File: rtl/puerta_pkg.sv
// Shared constants for the door controller: clock rate and default timing
// windows, plus a helper for sizing counters.
package puerta_pkg;

    localparam int unsigned CLK_HZ        = 50000000;
    localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned HOLD_MS     = 1000;
    localparam int unsigned FAULT_MS    = 10000;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = DEBOUNCE_MS * CYCLES_PER_MS;
    localparam int unsigned DEF_HOLD_CYCLES     = HOLD_MS * CYCLES_PER_MS;
    localparam int unsigned DEF_FAULT_CYCLES    = FAULT_MS * CYCLES_PER_MS;

    // Bits needed to hold values 0..maxval, never less than one.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Two-flop synchroniser followed by a consecutive-cycle debouncer for one
// asynchronous input.
module debounce_channel
    import puerta_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any agreeing cycle restarts the count, so only unbroken runs are accepted.
    always_comb begin
        s1_d     = din;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) stable_d = s2_q;
            else                   cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the raw presence and obstacle pins for the door FSM: debounce,
// presence stretch with rise pulse, and obstacle stuck-high detection.
module sensor_conditioner
    import puerta_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned FAULT_CYCLES    = DEF_FAULT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sense_raw,
    input  logic obs_raw,
    output logic sense,
    output logic obs,
    output logic sense_rise,
    output logic obs_fault
);

    localparam int unsigned   HW         = cnt_width(HOLD_CYCLES);
    localparam int unsigned   FW         = cnt_width(FAULT_CYCLES);
    localparam logic          STRETCH_EN = (HOLD_CYCLES != 0);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [FW-1:0] FAULT_MAX  = FW'(FAULT_CYCLES);

    logic          stable_sense, stable_obs;
    logic          sense_prev_q, sense_prev_d;
    logic          sense_dly_q, sense_dly_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [FW-1:0] fault_q, fault_d;
    logic          sense_fall;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sense_db (
        .clk (clk),
        .rst (rst),
        .din (sense_raw),
        .dout(stable_sense)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_obs_db (
        .clk (clk),
        .rst (rst),
        .din (obs_raw),
        .dout(stable_obs)
    );

    // The fall is seen one cycle late, so that cycle is covered by the fall
    // term itself and the countdown starts one lower to give exactly
    // HOLD_CYCLES of stretch.
    assign sense_fall = STRETCH_EN & sense_prev_q & ~stable_sense;
    assign sense      = stable_sense | sense_fall | (hold_q != '0);

    always_comb begin
        sense_prev_d = stable_sense;
        sense_dly_d  = sense;
        hold_d       = hold_q;
        if (stable_sense)        hold_d = '0;
        else if (sense_fall)     hold_d = HOLD_LOAD;
        else if (hold_q != '0)   hold_d = hold_q - HW'(1);
        fault_d = fault_q;
        if (!stable_obs)             fault_d = '0;
        else if (fault_q != FAULT_MAX) fault_d = fault_q + FW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sense_prev_q <= 1'b0;
            sense_dly_q  <= 1'b0;
            hold_q       <= '0;
            fault_q      <= '0;
        end else begin
            sense_prev_q <= sense_prev_d;
            sense_dly_q  <= sense_dly_d;
            hold_q       <= hold_d;
            fault_q      <= fault_d;
        end
    end

    assign sense_rise = sense & ~sense_dly_q;
    assign obs        = stable_obs;
    // Gated by the live obstacle so the fault drops in the same cycle as obs.
    assign obs_fault  = stable_obs & (fault_q == FAULT_MAX);

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: expected output vectors are queued
// against absolute edge numbers and checked on the falling edge.
module tb_sensor_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned H = 8;
    localparam int unsigned F = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sense_raw = 1'b0;
    logic obs_raw = 1'b0;
    logic sense, obs, sense_rise, obs_fault;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .FAULT_CYCLES   (F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sense_raw (sense_raw),
        .obs_raw   (obs_raw),
        .sense     (sense),
        .obs       (obs),
        .sense_rise(sense_rise),
        .obs_fault (obs_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Output vector order: {sense, sense_rise, obs, obs_fault}
    task automatic compare(input logic [3:0] v, input string tag);
        logic [3:0] got;
        got = {sense, sense_rise, obs, obs_fault};
        n_cmp++;
        assert (got === v) else begin
            n_bad++;
            $error("FAIL %s: got %b want %b {sense,rise,obs,fault} at edge %0d", tag, got, v, cyc);
        end
    endtask

    // Edge 0 is the next rising edge after the inputs are driven.
    task automatic mark();
        base = cyc + 1;
    endtask

    function automatic void expect_at(input int rel, input logic [3:0] v, input string tag);
        sb.push_back('{base + rel, v, tag});
    endfunction

    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                compare(e.v, e.tag);
            end
        end
    endtask

    initial begin
        step(2);
        compare(4'b0000, "in_reset");
        rst = 1'b0;
        step(2);
        compare(4'b0000, "post_reset");

        // clean assert and plain release
        mark();
        sense_raw = 1'b1;
        expect_at(4,  4'b0000, "t1_latency");
        expect_at(5,  4'b1100, "t1_rise");
        expect_at(6,  4'b1000, "t1_rise_end");
        expect_at(20, 4'b1000, "t1_hold_last");
        expect_at(21, 4'b0000, "t1_hold_done");
        step(8);
        sense_raw = 1'b0;
        step(16);

        // glitch rejection, presence
        mark();
        sense_raw = 1'b1;
        for (int k = 0; k <= 12; k++) expect_at(k, 4'b0000, "t2_sense_glitch");
        step(3);
        sense_raw = 1'b0;
        step(10);

        // glitch rejection, obstacle 3 high / 1 low / 3 high
        mark();
        obs_raw = 1'b1;
        for (int k = 0; k <= 14; k++) expect_at(k, 4'b0000, "t2_obs_glitch");
        step(3);
        obs_raw = 1'b0;
        step(1);
        obs_raw = 1'b1;
        step(3);
        obs_raw = 1'b0;
        step(8);

        // hold stretch after 20 high cycles
        mark();
        sense_raw = 1'b1;
        expect_at(5,  4'b1100, "t3_rise");
        expect_at(6,  4'b1000, "t3_rise_end");
        expect_at(24, 4'b1000, "t3_pre_fall");
        expect_at(25, 4'b1000, "t3_fall_stretched");
        expect_at(32, 4'b1000, "t3_hold_last");
        expect_at(33, 4'b0000, "t3_hold_done");
        step(20);
        sense_raw = 1'b0;
        step(16);

        // re-detection at hold count 3: no dip, no second pulse
        mark();
        sense_raw = 1'b1;
        expect_at(5, 4'b1100, "t3r_rise");
        expect_at(6, 4'b1000, "t3r_rise_end");
        for (int k = 24; k <= 33; k++) expect_at(k, 4'b1000, "t3r_no_dip");
        expect_at(52, 4'b1000, "t3r_hold_last");
        expect_at(53, 4'b0000, "t3r_hold_done");
        step(20);
        sense_raw = 1'b0;
        step(6);
        sense_raw = 1'b1;
        step(14);
        sense_raw = 1'b0;
        step(16);

        // obstacle fault
        mark();
        obs_raw = 1'b1;
        expect_at(4,  4'b0000, "t4_latency");
        expect_at(5,  4'b0010, "t4_obs_up");
        expect_at(20, 4'b0010, "t4_pre_fault");
        expect_at(21, 4'b0011, "t4_fault_up");
        expect_at(34, 4'b0011, "t4_fault_held");
        expect_at(35, 4'b0000, "t4_fault_drop");
        step(30);
        obs_raw = 1'b0;
        step(8);

        // reset mid-hold (hold = 5)
        mark();
        sense_raw = 1'b1;
        expect_at(5,  4'b1100, "t5h_rise");
        expect_at(18, 4'b1000, "t5h_in_hold");
        step(10);
        sense_raw = 1'b0;
        step(9);
        rst = 1'b1;
        #1;
        compare(4'b0000, "t5h_rst_now");
        step(2);
        rst = 1'b0;
        step(2);
        compare(4'b0000, "t5h_after_rst");

        // reset mid-debounce (counter = 2), inputs held high through reset
        mark();
        sense_raw = 1'b1;
        obs_raw = 1'b1;
        expect_at(3, 4'b0000, "t5d_pre_rst");
        step(4);
        rst = 1'b1;
        #1;
        compare(4'b0000, "t5d_rst_now");
        step(2);
        rst = 1'b0;
        mark();
        expect_at(4,  4'b0000, "t5d_restart_lat");
        expect_at(5,  4'b1110, "t5d_restart_up");
        expect_at(6,  4'b1010, "t5d_rise_end");
        expect_at(12, 4'b1010, "t5d_pre_fall");
        expect_at(13, 4'b1000, "t5d_obs_fall");
        expect_at(20, 4'b1000, "t5d_hold_last");
        expect_at(21, 4'b0000, "t5d_hold_done");
        step(8);
        sense_raw = 1'b0;
        obs_raw = 1'b0;
        step(16);

        // simultaneous rise on both inputs
        mark();
        sense_raw = 1'b1;
        obs_raw = 1'b1;
        expect_at(4,  4'b0000, "t6_latency");
        expect_at(5,  4'b1110, "t6_both_up");
        expect_at(6,  4'b1010, "t6_rise_end");
        expect_at(15, 4'b1000, "t6_obs_fall");
        expect_at(22, 4'b1000, "t6_hold_last");
        expect_at(23, 4'b0000, "t6_hold_done");
        step(10);
        sense_raw = 1'b0;
        obs_raw = 1'b0;
        step(16);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL sb_drain: %0d expectations left unchecked, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
